// File: rtl/oled_spi_responder_pkg.sv
// Shared opcodes, reset defaults and decoder state type for the OLED SPI responder.
// The horizontal addressing type is only consumed when OLED_RX_HORIZ_ADDR_EN is defined.
package oled_pkg;

    localparam int FB_ADDR_W = 9;

    localparam logic [7:0] OLED_CMD_DISP_OFF    = 8'hAE;
    localparam logic [7:0] OLED_CMD_DISP_ON     = 8'hAF;
    localparam logic [7:0] OLED_CMD_SEG_NORM    = 8'hA0;
    localparam logic [7:0] OLED_CMD_SEG_REMAP   = 8'hA1;
    localparam logic [7:0] OLED_CMD_COM_NORM    = 8'hC0;
    localparam logic [7:0] OLED_CMD_COM_REV     = 8'hC8;
    localparam logic [7:0] OLED_CMD_ENTIRE_OFF  = 8'hA4;
    localparam logic [7:0] OLED_CMD_ENTIRE_ON   = 8'hA5;
    localparam logic [7:0] OLED_CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] OLED_CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] OLED_CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OLED_CMD_COM_CFG     = 8'hDA;
    localparam logic [7:0] OLED_CMD_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] OLED_CMD_ADDR_MODE   = 8'h20;

    localparam logic [7:0] CONTRAST_RST  = 8'h7F;
    localparam logic [7:0] PRECHARGE_RST = 8'h22;
    localparam logic [7:0] COM_CFG_RST   = 8'h12;
    localparam logic [1:0] PAGE_END_RST  = 2'd3;

    typedef enum logic [3:0] {
        CMD,
        ARG_CONTRAST,
        ARG_PUMP,
        ARG_PRECHG,
        ARG_COM,
        ARG_PAGE_START,
        ARG_PAGE_END,
        ARG_MODE,
        ARG_DISCARD
    } dec_state_t;

    typedef enum logic [1:0] {
        ADDR_HORIZ = 2'b00,
        ADDR_PAGE  = 2'b10
    } addr_mode_t;

    // Only 00 selects horizontal; every other encoding falls back to page mode.
    function automatic addr_mode_t decode_addr_mode(input logic [1:0] arg);
        return (arg == 2'b00) ? ADDR_HORIZ : ADDR_PAGE;
    endfunction

endpackage

// File: rtl/oled_spi_responder_if.sv
// OLED link bundle: serial/panel-control lines from the controller plus the framebuffer write port.
interface oled_spi_responder_if;
    import oled_pkg::*;

    logic                 oled_spi_clk;
    logic                 oled_spi_data;
    logic                 oled_dc_n;
    logic                 oled_reset_n;
    logic                 oled_vdd;
    logic                 oled_vbat;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_wdata;

    modport master (
        output oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n, oled_vdd, oled_vbat,
        input  fb_we, fb_addr, fb_wdata
    );

    modport slave (
        input  oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n, oled_vdd, oled_vbat,
        output fb_we, fb_addr, fb_wdata
    );

endinterface

// File: rtl/oled_spi_responder_deser.sv
// Synchronizes the OLED link inputs and frames the serial stream into bytes.
// A stalled SCLK for IDLE_TIMEOUT clocks discards any partial byte.
module oled_spi_deser #(
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_data,
    input  logic       dc_n,
    input  logic       panel_reset_n,
    input  logic       vdd_n,
    input  logic       vbat_n,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       panel_reset_n_sync,
    output logic       vdd_n_sync,
    output logic       vbat_n_sync
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [1:0]        sclk_ff, mosi_ff, dc_ff, rstn_ff, vdd_ff, vbat_ff;
    logic              sclk_prev;
    logic              sclk_rise;
    logic [2:0]        bit_cnt;
    logic [6:0]        shift;
    logic [IDLE_W-1:0] idle_cnt;

    // Supplies come up "off" so nothing is framed until the controller powers the panel.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_ff   <= '0;
            mosi_ff   <= '0;
            dc_ff     <= '0;
            rstn_ff   <= '0;
            vdd_ff    <= 2'b11;
            vbat_ff   <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[0], spi_clk};
            mosi_ff   <= {mosi_ff[0], spi_data};
            dc_ff     <= {dc_ff[0], dc_n};
            rstn_ff   <= {rstn_ff[0], panel_reset_n};
            vdd_ff    <= {vdd_ff[0], vdd_n};
            vbat_ff   <= {vbat_ff[0], vbat_n};
            sclk_prev <= sclk_ff[1];
        end
    end

    assign sclk_rise          = sclk_ff[1] & ~sclk_prev;
    assign panel_reset_n_sync = rstn_ff[1];
    assign vdd_n_sync         = vdd_ff[1];
    assign vbat_n_sync        = vbat_ff[1];

    always_ff @(posedge clock) begin
        if (reset || !rstn_ff[1] || vdd_ff[1]) begin
            bit_cnt    <= '0;
            shift      <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (sclk_rise) begin
                idle_cnt <= '0;
                shift    <= {shift[5:0], mosi_ff[1]};
                if (bit_cnt == 3'd7) begin
                    bit_cnt    <= '0;
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_ff[1]};
                    byte_dc    <= dc_ff[1];
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else if (idle_cnt == IDLE_LAST) begin
                bit_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oled_spi_responder.sv
// Display-side end of the OLED SPI link: decodes the SSD1306-style command subset and
// writes data bytes to a 512x8 framebuffer. Define OLED_RX_HORIZ_ADDR_EN for horizontal addressing.
module oled_spi_responder
    import oled_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 64,
    parameter int NUM_PAGES    = 4,
    parameter int NUM_COLS     = 128
) (
    input  logic                 clock,
    input  logic                 reset,
    oled_spi_responder_if.slave  link,
    output logic                 display_on,
    output logic [7:0]           contrast,
    output logic                 charge_pump_en,
    output logic [7:0]           precharge,
    output logic [7:0]           com_cfg,
    output logic                 seg_remap,
    output logic                 com_scan_rev,
    output logic                 entire_on,
    output logic                 cmd_error
);

    localparam int PAGE_W = $clog2(NUM_PAGES);
    localparam int COL_W  = $clog2(NUM_COLS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    logic              byte_valid, byte_dc, rstn_s, vdd_s, unused_vbat_s;
    logic [7:0]        byte_data;

    dec_state_t        st, st_n;
    logic [PAGE_W-1:0] page_q, page_n, page_end_q, page_end_n;
    logic [COL_W-1:0]  col_q, col_n;
    logic              disp_n, pump_n, seg_n, scan_n, entire_n, err_n;
    logic [7:0]        contrast_n, prechg_n, com_n;
    logic              we_q, we_n;
    logic [FB_ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        wdata_q, wdata_n;
`ifdef OLED_RX_HORIZ_ADDR_EN
    logic [PAGE_W-1:0] page_start_q, page_start_n;
    addr_mode_t        mode_q, mode_n;
`endif

    oled_spi_deser #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_deser (
        .clock              (clock),
        .reset              (reset),
        .spi_clk            (link.oled_spi_clk),
        .spi_data           (link.oled_spi_data),
        .dc_n               (link.oled_dc_n),
        .panel_reset_n      (link.oled_reset_n),
        .vdd_n              (link.oled_vdd),
        .vbat_n             (link.oled_vbat),
        .byte_valid         (byte_valid),
        .byte_data          (byte_data),
        .byte_dc            (byte_dc),
        .panel_reset_n_sync (rstn_s),
        .vdd_n_sync         (vdd_s),
        .vbat_n_sync        (unused_vbat_s)
    );

    assign link.fb_we    = we_q;
    assign link.fb_addr  = addr_q;
    assign link.fb_wdata = wdata_q;

    // Panel reset also drops a byte finishing in the same cycle, so reset values always win.
    always_ff @(posedge clock) begin
        if (reset || !rstn_s) begin
            st             <= CMD;
            page_q         <= '0;
            page_end_q     <= PAGE_END_RST;
            col_q          <= '0;
            display_on     <= 1'b0;
            contrast       <= CONTRAST_RST;
            charge_pump_en <= 1'b0;
            precharge      <= PRECHARGE_RST;
            com_cfg        <= COM_CFG_RST;
            seg_remap      <= 1'b0;
            com_scan_rev   <= 1'b0;
            entire_on      <= 1'b0;
            cmd_error      <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
`ifdef OLED_RX_HORIZ_ADDR_EN
            page_start_q   <= '0;
            mode_q         <= ADDR_PAGE;
`endif
        end else begin
            st             <= st_n;
            page_q         <= page_n;
            page_end_q     <= page_end_n;
            col_q          <= col_n;
            display_on     <= disp_n;
            contrast       <= contrast_n;
            charge_pump_en <= pump_n;
            precharge      <= prechg_n;
            com_cfg        <= com_n;
            seg_remap      <= seg_n;
            com_scan_rev   <= scan_n;
            entire_on      <= entire_n;
            cmd_error      <= err_n;
            we_q           <= we_n;
            addr_q         <= addr_n;
            wdata_q        <= wdata_n;
`ifdef OLED_RX_HORIZ_ADDR_EN
            page_start_q   <= page_start_n;
            mode_q         <= mode_n;
`endif
        end
    end

    always_comb begin
        st_n       = st;
        page_n     = page_q;
        page_end_n = page_end_q;
        col_n      = col_q;
        disp_n     = display_on;
        contrast_n = contrast;
        pump_n     = charge_pump_en;
        prechg_n   = precharge;
        com_n      = com_cfg;
        seg_n      = seg_remap;
        scan_n     = com_scan_rev;
        entire_n   = entire_on;
        err_n      = 1'b0;
        we_n       = 1'b0;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
`ifdef OLED_RX_HORIZ_ADDR_EN
        page_start_n = page_start_q;
        mode_n       = mode_q;
`endif
        if (byte_valid) begin
            // Data bytes bypass the decoder state so a pending argument survives them.
            if (byte_dc) begin
                we_n    = 1'b1;
                addr_n  = {page_q, col_q};
                wdata_n = byte_data;
                if (col_q == COL_LAST) begin
                    col_n = '0;
`ifdef OLED_RX_HORIZ_ADDR_EN
                    if (mode_q == ADDR_HORIZ)
                        page_n = (page_q == page_end_q) ? page_start_q : page_q + 1'b1;
`endif
                end else begin
                    col_n = col_q + 1'b1;
                end
            end else begin
                case (st)
                    CMD: begin
                        case (byte_data)
                            OLED_CMD_DISP_OFF:    disp_n   = 1'b0;
                            OLED_CMD_DISP_ON:     disp_n   = 1'b1;
                            OLED_CMD_SEG_NORM:    seg_n    = 1'b0;
                            OLED_CMD_SEG_REMAP:   seg_n    = 1'b1;
                            OLED_CMD_COM_NORM:    scan_n   = 1'b0;
                            OLED_CMD_COM_REV:     scan_n   = 1'b1;
                            OLED_CMD_ENTIRE_OFF:  entire_n = 1'b0;
                            OLED_CMD_ENTIRE_ON:   entire_n = 1'b1;
                            OLED_CMD_CONTRAST:    st_n     = ARG_CONTRAST;
                            OLED_CMD_CHARGE_PUMP: st_n     = ARG_PUMP;
                            OLED_CMD_PRECHARGE:   st_n     = ARG_PRECHG;
                            OLED_CMD_COM_CFG:     st_n     = ARG_COM;
                            OLED_CMD_PAGE_ADDR:   st_n     = ARG_PAGE_START;
                            OLED_CMD_ADDR_MODE: begin
`ifdef OLED_RX_HORIZ_ADDR_EN
                                st_n  = ARG_MODE;
`else
                                err_n = 1'b1;
                                st_n  = ARG_DISCARD;
`endif
                            end
                            default: begin
                                if (byte_data[7:4] == 4'h0)
                                    col_n[3:0] = byte_data[3:0];
                                else if (byte_data[7:3] == 5'b00010)
                                    col_n[6:4] = byte_data[2:0];
                                else
                                    err_n = 1'b1;
                            end
                        endcase
                    end
                    ARG_CONTRAST: begin contrast_n = byte_data;    st_n = CMD; end
                    ARG_PUMP:     begin pump_n     = byte_data[2]; st_n = CMD; end
                    ARG_PRECHG:   begin prechg_n   = byte_data;    st_n = CMD; end
                    ARG_COM:      begin com_n      = byte_data;    st_n = CMD; end
                    ARG_PAGE_START: begin
                        page_n = byte_data[PAGE_W-1:0];
`ifdef OLED_RX_HORIZ_ADDR_EN
                        page_start_n = byte_data[PAGE_W-1:0];
`endif
                        st_n = ARG_PAGE_END;
                    end
                    ARG_PAGE_END: begin page_end_n = byte_data[PAGE_W-1:0]; st_n = CMD; end
                    ARG_MODE: begin
`ifdef OLED_RX_HORIZ_ADDR_EN
                        mode_n = decode_addr_mode(byte_data[1:0]);
`endif
                        st_n = CMD;
                    end
                    default: st_n = CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_responder.sv
// Directed bench for oled_spi_responder: a command-vector table plus hand-written link sequences.
module tb_oled_spi_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic       display_on, charge_pump_en, seg_remap, com_scan_rev, entire_on, cmd_error;
    logic [7:0] contrast, precharge, com_cfg;

    int tests_run = 0;
    int tests_failed = 0;
    int err_cnt = 0;
    logic [16:0] fb_q[$];

    typedef enum {F_NONE, F_DISP, F_CONTRAST, F_PUMP, F_PRECHG, F_COMCFG, F_SEG, F_SCAN, F_ENTIRE} field_e;
    typedef struct {
        logic [7:0] data;
        logic       dc;
        field_e     field;
        logic [7:0] expect_val;
    } vec_t;
    vec_t vecs[$];

    oled_spi_responder_if link();

    oled_spi_responder dut (
        .clock          (clock),
        .reset          (reset),
        .link           (link),
        .display_on     (display_on),
        .contrast       (contrast),
        .charge_pump_en (charge_pump_en),
        .precharge      (precharge),
        .com_cfg        (com_cfg),
        .seg_remap      (seg_remap),
        .com_scan_rev   (com_scan_rev),
        .entire_on      (entire_on),
        .cmd_error      (cmd_error)
    );

    always #5 clock = ~clock;

    // Record every framebuffer write and every cycle cmd_error is high.
    always @(negedge clock) begin
        if (link.fb_we) fb_q.push_back({link.fb_addr, link.fb_wdata});
        if (cmd_error) err_cnt++;
    end

    task automatic wait_clocks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // 10 MHz SCLK: 5 system clocks per half period, MSB first.
    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        link.oled_dc_n = dc;
        for (int i = 7; i >= 8 - nbits; i--) begin
            link.oled_spi_data = b[i];
            wait_clocks(5);
            link.oled_spi_clk = 1'b1;
            wait_clocks(5);
            link.oled_spi_clk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
        wait_clocks(8);
    endtask

    function automatic logic [7:0] get_field(input field_e f);
        case (f)
            F_DISP:     return {7'd0, display_on};
            F_CONTRAST: return contrast;
            F_PUMP:     return {7'd0, charge_pump_en};
            F_PRECHG:   return precharge;
            F_COMCFG:   return com_cfg;
            F_SEG:      return {7'd0, seg_remap};
            F_SCAN:     return {7'd0, com_scan_rev};
            F_ENTIRE:   return {7'd0, entire_on};
            default:    return 8'h00;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_display_on"}, {31'd0, display_on}, 32'd0);
        checkOutput({tag, "_contrast"}, {24'd0, contrast}, 32'h7F);
        checkOutput({tag, "_pump"}, {31'd0, charge_pump_en}, 32'd0);
        checkOutput({tag, "_precharge"}, {24'd0, precharge}, 32'h22);
        checkOutput({tag, "_com_cfg"}, {24'd0, com_cfg}, 32'h12);
        checkOutput({tag, "_seg_remap"}, {31'd0, seg_remap}, 32'd0);
        checkOutput({tag, "_com_scan"}, {31'd0, com_scan_rev}, 32'd0);
        checkOutput({tag, "_entire_on"}, {31'd0, entire_on}, 32'd0);
        checkOutput({tag, "_fb_we"}, {31'd0, link.fb_we}, 32'd0);
        checkOutput({tag, "_cmd_error"}, {31'd0, cmd_error}, 32'd0);
    endtask

    task automatic check_write(input string name, input int idx, input logic [8:0] addr, input logic [7:0] data);
        logic [16:0] got;
        got = (idx < fb_q.size()) ? fb_q[idx] : 17'h1FFFF;
        checkOutput(name, {15'd0, got}, {15'd0, addr, data});
    endtask

    initial begin
        int base;

        vecs.push_back('{8'hAE, 1'b0, F_DISP,     8'h00});
        vecs.push_back('{8'h8D, 1'b0, F_PUMP,     8'h00});
        vecs.push_back('{8'h14, 1'b0, F_PUMP,     8'h01});
        vecs.push_back('{8'hD9, 1'b0, F_PRECHG,   8'h22});
        vecs.push_back('{8'hF1, 1'b0, F_PRECHG,   8'hF1});
        vecs.push_back('{8'h81, 1'b0, F_CONTRAST, 8'h7F});
        vecs.push_back('{8'hFF, 1'b0, F_CONTRAST, 8'hFF});
        vecs.push_back('{8'hA0, 1'b0, F_SEG,      8'h00});
        vecs.push_back('{8'hC0, 1'b0, F_SCAN,     8'h00});
        vecs.push_back('{8'hDA, 1'b0, F_COMCFG,   8'h12});
        vecs.push_back('{8'h00, 1'b0, F_COMCFG,   8'h00});
        vecs.push_back('{8'hAF, 1'b0, F_DISP,     8'h01});
        vecs.push_back('{8'hA1, 1'b0, F_SEG,      8'h01});
        vecs.push_back('{8'hC8, 1'b0, F_SCAN,     8'h01});
        vecs.push_back('{8'hA5, 1'b0, F_ENTIRE,   8'h01});
        vecs.push_back('{8'hA4, 1'b0, F_ENTIRE,   8'h00});
        vecs.push_back('{8'hA0, 1'b0, F_SEG,      8'h00});
        vecs.push_back('{8'hC0, 1'b0, F_SCAN,     8'h00});

        link.oled_spi_clk  = 1'b0;
        link.oled_spi_data = 1'b0;
        link.oled_dc_n     = 1'b0;
        link.oled_reset_n  = 1'b1;
        link.oled_vdd      = 1'b0;
        link.oled_vbat     = 1'b0;
        wait_clocks(5);
        reset = 1'b0;
        wait_clocks(6);
        check_reset_values("por");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].data, vecs[i].dc);
            if (vecs[i].field != F_NONE)
                checkOutput($sformatf("vec%0d", i), {24'd0, get_field(vecs[i].field)}, {24'd0, vecs[i].expect_val});
        end
        checkOutput("init_no_error", err_cnt, 0);
        checkOutput("init_no_write", fb_q.size(), 0);

        fb_q.delete();
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h42, 1'b1);
        checkOutput("page1_write_count", fb_q.size(), 2);
        check_write("page1_write0", 0, 9'h080, 8'h3C);
        check_write("page1_write1", 1, 9'h081, 8'h42);

        fb_q.delete();
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h17, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'h55, 1'b1);
        checkOutput("wrap_write_count", fb_q.size(), 2);
        check_write("wrap_write0", 0, 9'h17F, 8'hAA);
        check_write("wrap_write1", 1, 9'h100, 8'h55);

        fb_q.delete();
        send_bits(8'hFF, 1'b1, 5);
        wait_clocks(70);
        applyStimulus(8'h81, 1'b1);
        checkOutput("timeout_write_count", fb_q.size(), 1);
        check_write("timeout_write0", 0, 9'h101, 8'h81);

        fb_q.delete();
        applyStimulus(8'h81, 1'b0);
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'h33, 1'b0);
        checkOutput("pending_arg_contrast", {24'd0, contrast}, 32'h33);
        checkOutput("pending_arg_write_count", fb_q.size(), 1);
        check_write("pending_arg_write0", 0, 9'h102, 8'h5A);

        base = err_cnt;
        applyStimulus(8'hE3, 1'b0);
        checkOutput("bad_opcode_error_cycles", err_cnt - base, 1);
        base = err_cnt;
        fb_q.delete();
        applyStimulus(8'h18, 1'b0);
        applyStimulus(8'h11, 1'b1);
        checkOutput("col_hi_reserved_error", err_cnt - base, 1);
        check_write("col_hi_reserved_addr", 0, 9'h103, 8'h11);

        base = err_cnt;
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'hAE, 1'b0);
`ifdef OLED_RX_HORIZ_ADDR_EN
        checkOutput("addr_mode_error", err_cnt - base, 0);
`else
        checkOutput("addr_mode_error", err_cnt - base, 1);
`endif
        checkOutput("addr_mode_arg_consumed", {31'd0, display_on}, 32'd1);

        fb_q.delete();
        link.oled_vdd = 1'b1;
        wait_clocks(4);
        applyStimulus(8'h99, 1'b1);
        link.oled_vdd = 1'b0;
        wait_clocks(4);
        checkOutput("vdd_off_ignored", fb_q.size(), 0);

        send_bits(8'hC3, 1'b0, 4);
        link.oled_reset_n = 1'b0;
        wait_clocks(6);
        check_reset_values("panel_rst");
        link.oled_reset_n = 1'b1;
        wait_clocks(4);
        fb_q.delete();
        applyStimulus(8'hAF, 1'b0);
        checkOutput("post_rst_display_on", {31'd0, display_on}, 32'd1);
        applyStimulus(8'h77, 1'b1);
        checkOutput("post_rst_write_count", fb_q.size(), 1);
        check_write("post_rst_write0", 0, 9'h000, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/oled_spi_responder.md
Name: oled_spi_responder

Overview:
- Display-side model of the OLED SPI link: receives the byte stream driven by the OLED controller and decodes the SSD1306-style command subset that controller emits.
- Tracks page/column addressing and writes GDDRAM data bytes to an external 512x8 framebuffer port.
- Exposes the decoded panel state.
- Used as a synthesizable loopback target and as the bench's reference end of the link.

Parameters:
- IDLE_TIMEOUT, 64, system clocks with no SCLK rising edge after which a partial byte is discarded.
- NUM_PAGES, 4, pages in the framebuffer (fixed at 4; 2-bit page field).
- NUM_COLS, 128, columns per page.

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- oled_spi_clk  in  1  serial clock from controller, at most clock/4
- oled_spi_data  in  1  serial data, MSB first
- oled_dc_n  in  1  0 = command byte, 1 = data byte
- oled_reset_n  in  1  active-low panel reset
- oled_vdd  in  1  active-low logic supply enable
- oled_vbat  in  1  active-low panel supply enable
- fb_we  out  1  framebuffer write strobe, one-cycle pulse
- fb_addr  out  9  {page[1:0], col[6:0]}
- fb_wdata  out  8  data byte
- display_on  out  1  set by 0xAF, cleared by 0xAE
- contrast  out  8  contrast register
- charge_pump_en  out  1  bit 2 of the 0x8D argument
- precharge  out  8  0xD9 argument
- com_cfg  out  8  0xDA argument
- seg_remap  out  1  0xA0 -> 0, 0xA1 -> 1
- com_scan_rev  out  1  0xC0 -> 0, 0xC8 -> 1
- entire_on  out  1  0xA5 -> 1, 0xA4 -> 0
- cmd_error  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Input sync: all six inputs pass through 2-flop synchronizers. An SCLK rising edge is detected from the synchronized value; on that edge MOSI is shifted into an 8-bit register.
- Byte framing: a byte completes on the 8th rising edge. oled_dc_n is sampled on that same edge.
- Bit counter clears to 0 on any of:
  - reset;
  - oled_reset_n = 0;
  - oled_vdd = 1;
  - IDLE_TIMEOUT clocks without an SCLK edge.
- Byte-done latency: the internal byte strobe occurs 3 clocks after the 8th SCLK rising edge at the pin.
- Reset values (reset, or synchronized oled_reset_n = 0):
  - display_on = 0, contrast = 0x7F, charge_pump_en = 0, precharge = 0x22, com_cfg = 0x12;
  - seg_remap = 0, com_scan_rev = 0, entire_on = 0;
  - page = 0, col = 0, page_end = 3;
  - fb_we = 0, cmd_error = 0;
  - decoder FSM = CMD.
- Bytes are ignored while oled_vdd = 1. oled_vbat is ignored for decoding.
- Decoder FSM states: CMD, ARG_CONTRAST, ARG_PUMP, ARG_PRECHG, ARG_COM, ARG_PAGE_START, ARG_PAGE_END, ARG_MODE, ARG_DISCARD.
- Command bytes in CMD state:
  - 0xAE/0xAF, 0xA0/0xA1, 0xC0/0xC8, 0xA4/0xA5: update the named output and stay in CMD.
  - 0x81 -> ARG_CONTRAST; 0x8D -> ARG_PUMP; 0xD9 -> ARG_PRECHG; 0xDA -> ARG_COM; 0x22 -> ARG_PAGE_START.
  - 0x00-0x0F: col[3:0] = byte[3:0].
  - 0x10-0x17: col[6:4] = byte[2:0].
  - 0x18-0x1F: cmd_error pulse, column unchanged.
  - Any other opcode: cmd_error pulse, stay in CMD.
- Argument states:
  - Each argument byte writes its register, then returns to CMD.
  - ARG_PAGE_START: page = byte[1:0], then -> ARG_PAGE_END.
  - ARG_PAGE_END: page_end = byte[1:0], then -> CMD.
- Data bytes (dc_n = 1) are accepted in any state and do not disturb a pending argument state.
  - Each data byte produces fb_we = 1 for exactly one clock, with fb_addr = {page, col} and fb_wdata = byte.
  - col then increments.
  - Page addressing mode: col wraps 127 -> 0 and page is unchanged.
- Simultaneous events: a byte completing in the same cycle as oled_reset_n falling is dropped, and reset values win.

Optional Feature:
- Macro: OLED_RX_HORIZ_ADDR_EN.
- Defined:
  - 0x20 -> ARG_MODE; the argument's bits[1:0] set addr_mode (00 = horizontal, 10 = page, others = page).
  - Horizontal mode: on col wrap 127 -> 0, page increments; after page_end it wraps to the page-start value.
- Undefined:
  - 0x20 pulses cmd_error and moves to ARG_DISCARD; the next command byte is consumed silently.
  - Page mode only.

Decomposition:
- Package oled_pkg holds:
  - opcode constants (OLED_CMD_DISP_OFF = 0xAE, etc.);
  - decoder state enum;
  - reset-default constants;
  - FB_ADDR_W = 9.
- Sub-module oled_spi_deser holds the synchronizers, SCLK edge detect, shift register, bit counter and idle timeout. It outputs byte_valid, byte_data[7:0] and byte_dc.

Test Plan:
- Power-up init stream: command bytes AE 8D 14 D9 F1 81 FF A0 C0 DA 00 AF at 10 MHz SCLK -> display_on = 1, contrast = 0xFF, charge_pump_en = 1, precharge = 0xF1, com_cfg = 0x00, no cmd_error.
- Command bytes 22 01 01 10, then data bytes 3C 42 -> fb_we pulses twice; fb_addr = 0x080 with fb_wdata = 0x3C, then fb_addr = 0x081 with fb_wdata = 0x42.
- Command bytes 22 02 02 17 0F, then data bytes AA 55 -> writes at 0x17F, then 0x100 (column wrap, page stays 2).
- Stop SCLK after 5 bits for 70 clocks, then send data byte 81 -> exactly one write of 0x81, no corrupted byte.
- Command bytes 81, then data byte 5A, then command byte 33 -> contrast = 0x33; the 0x5A write happens at {page, col} without disturbing the pending argument state.
- Command byte 0xE3 -> cmd_error high for 1 clock. Drop oled_reset_n mid-byte -> all outputs return to reset values and the next full byte decodes correctly.
